huffman_byte_packer: RTL and testbench

- Receive-side counterpart of the encoder's block-to-byte serializer.
- Collects a stream of 8-bit bytes back into one 160-bit block (20 bytes); byte 0 goes in the LSB lane.
- Presents the block to the downstream consumer with a valid/ready handshake and back-pressures the byte source while a block is pending.
- Supports flushing a partial block at end of stream.

---
 rtl/huffman_byte_packer_pkg.sv | 24 ++
 rtl/huffman_byte_packer_lane_decode.sv | 25 ++
 rtl/huffman_byte_packer.sv | 138 +++++++++++++
 tb/tb_huffman_byte_packer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_byte_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : huffman_pkg
// Description : Constants and types shared by the Huffman block serializer
//               and the receive-side byte packer. Both sides import these
//               values, so they always agree on lane ordering and block width.
// Revision    : 1.0 - initial release
// ============================================================================
package huffman_pkg;

    localparam int HUFF_BLOCK_BYTES = 20;
    localparam int HUFF_BYTE_W      = 8;
    localparam int HUFF_BLOCK_W     = HUFF_BLOCK_BYTES * HUFF_BYTE_W;
    localparam int HUFF_CNT_W       = 5;

    // A block is either being filled, or it is complete and waiting for a
    // handshake.
    typedef enum logic [0:0] {
        PACK_FILL = 1'b0,
        PACK_HOLD = 1'b1
    } pack_state_t;

endpackage
`default_nettype wire

// File: rtl/huffman_byte_packer_lane_decode.sv
`default_nettype none
// ============================================================================
// Module      : huffman_lane_decode
// Description : Converts the packer fill count into a one-hot per-lane write
//               enable. A count of NUM_BYTES or more selects no lane, so a
//               full block can never be overwritten.
// Revision    : 1.0 - initial release
// ============================================================================
module huffman_lane_decode
    import huffman_pkg::*;
#(
    parameter int NUM_BYTES = HUFF_BLOCK_BYTES,
    parameter int CNT_W     = HUFF_CNT_W
) (
    input  logic [CNT_W-1:0]     count_i,
    output logic [NUM_BYTES-1:0] lane_we_o
);

    // Each lane is enabled only when the count addresses it exactly.
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
        assign lane_we_o[gi] = (count_i == CNT_W'(gi));
    end

endmodule
`default_nettype wire

// File: rtl/huffman_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : huffman_byte_packer
// Description : Collects a stream of bytes into one NUM_BYTES-wide block,
//               with byte 0 in the LSB lane. The block is presented with a
//               valid/ready handshake, and the byte source is back-pressured
//               while a block is pending. A flush emits a partial block.
//               Optional macro HUFF_PACK_OVF_EN adds a sticky overflow output
//               that flags bytes dropped while byte_ready was low.
// Revision    : 1.0 - initial release
// ============================================================================
module huffman_byte_packer
    import huffman_pkg::*;
#(
    parameter int NUM_BYTES = HUFF_BLOCK_BYTES,
    parameter int BYTE_W    = HUFF_BYTE_W,
    parameter int CNT_W     = HUFF_CNT_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [BYTE_W-1:0]           byte_in,
    input  logic                        byte_enb,
    output logic                        byte_ready,
    input  logic                        flush,
    output logic [NUM_BYTES*BYTE_W-1:0] block_data,
    output logic                        block_valid,
    input  logic                        block_ready,
    output logic [CNT_W-1:0]            block_count
`ifdef HUFF_PACK_OVF_EN
    ,
    output logic                        overflow
`endif
);

    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(NUM_BYTES - 1);
    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(NUM_BYTES);

    pack_state_t                  state_q, state_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [CNT_W-1:0]             bcount_q, bcount_d;
    logic [NUM_BYTES*BYTE_W-1:0]  data_q, data_d;
    logic [NUM_BYTES-1:0]         lane_we;
    logic                         accept;

    // A pending block frees up on the same edge it is consumed, so the
    // source keeps streaming without a bubble.
    assign block_valid = (state_q == PACK_HOLD);
    assign byte_ready  = !block_valid || block_ready;
    assign accept      = byte_enb && byte_ready;
    assign block_data  = data_q;
    assign block_count = bcount_q;

    huffman_lane_decode #(
        .NUM_BYTES (NUM_BYTES),
        .CNT_W     (CNT_W)
    ) u_lane_decode (
        .count_i   (count_q),
        .lane_we_o (lane_we)
    );

    // Next-state logic: fill lanes, close a block when full or flushed, and
    // restart filling on the handshake (taking any same-edge byte as lane 0).
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        bcount_d = bcount_q;
        data_d   = data_q;
        case (state_q)
            PACK_FILL: begin
                if (accept) begin
                    for (int i = 0; i < NUM_BYTES; i++) begin
                        if (lane_we[i]) begin
                            data_d[i*BYTE_W +: BYTE_W] = byte_in;
                        end
                    end
                    count_d = count_q + CNT_W'(1);
                end
                if (accept && (count_q == C_LAST_IDX)) begin
                    state_d  = PACK_HOLD;
                    bcount_d = C_FULL_CNT;
                end else if (flush && (count_d != '0)) begin
                    state_d  = PACK_HOLD;
                    bcount_d = count_d;
                end
            end
            PACK_HOLD: begin
                if (block_ready) begin
                    state_d  = PACK_FILL;
                    bcount_d = '0;
                    data_d   = '0;
                    count_d  = '0;
                    if (accept) begin
                        data_d[BYTE_W-1:0] = byte_in;
                        count_d            = CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d  = PACK_FILL;
                count_d  = '0;
                bcount_d = '0;
                data_d   = '0;
            end
        endcase
    end

    // State, counters and lane registers; reset discards any partial block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= PACK_FILL;
            count_q  <= '0;
            bcount_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            bcount_q <= bcount_d;
            data_q   <= data_d;
        end
    end

`ifdef HUFF_PACK_OVF_EN
    logic ovf_q;

    // Sticky flag for any byte offered while the packer could not take it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (byte_enb && !byte_ready) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_huffman_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_huffman_byte_packer
// Description : Self-checking bench for huffman_byte_packer. Expected blocks
//               are queued when stimulus is driven and compared on each
//               block handshake. Build with HUFF_PACK_OVF_EN to include the
//               overflow checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_huffman_byte_packer;

    localparam int NB = 20;
    localparam int BW = 8;
    localparam int CW = 5;
    localparam int DW = NB * BW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [BW-1:0] byte_in = '0;
    logic          byte_enb = 1'b0;
    logic          byte_ready;
    logic          flush = 1'b0;
    logic [DW-1:0] block_data;
    logic          block_valid;
    logic          block_ready = 1'b0;
    logic [CW-1:0] block_count;
`ifdef HUFF_PACK_OVF_EN
    logic          overflow;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] cnt;
    } blk_t;

    blk_t sb[$];
    blk_t mon_b;
    int   checks = 0;
    int   errors = 0;

    huffman_byte_packer dut (
        .clk         (clk),
        .reset       (reset),
        .byte_in     (byte_in),
        .byte_enb    (byte_enb),
        .byte_ready  (byte_ready),
        .flush       (flush),
        .block_data  (block_data),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_count (block_count)
`ifdef HUFF_PACK_OVF_EN
        ,
        .overflow    (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] seq_block(input int first, input int n);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            v[i*BW +: BW] = BW'(first + i);
        end
        return v;
    endfunction

    task automatic expect_block(input logic [DW-1:0] d, input int n);
        blk_t b;
        b.data = d;
        b.cnt  = CW'(n);
        sb.push_back(b);
    endtask

    task automatic send_byte(input logic [BW-1:0] b, input logic fl);
        @(posedge clk);
        #1;
        byte_in  = b;
        byte_enb = 1'b1;
        flush    = fl;
    endtask

    task automatic idle(input logic fl);
        @(posedge clk);
        #1;
        byte_enb = 1'b0;
        flush    = fl;
    endtask

    // Consecutive bytes; no block may be presented while the run is filling.
    task automatic send_run(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(BW'(first + i), 1'b0);
            @(negedge clk);
            check_val("fill_no_valid", DW'(block_valid), DW'(0));
        end
    endtask

    // Monitor: ready equation, idle count, and scoreboard compare on handshake.
    always @(negedge clk) begin
        if (reset) begin
            check_val("byte_ready", DW'(byte_ready), DW'(!block_valid || block_ready));
            if (!block_valid) begin
                check_val("fill_count_zero", DW'(block_count), DW'(0));
            end
            if (block_valid && block_ready) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_block", DW'(block_valid), DW'(0));
                end else begin
                    mon_b = sb.pop_front();
                    check_val("blk_data", block_data, mon_b.data);
                    check_val("blk_count", DW'(block_count), DW'(mon_b.cnt));
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] v;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_valid", DW'(block_valid), DW'(0));
        check_val("rst_count", DW'(block_count), DW'(0));
        check_val("rst_data", block_data, DW'(0));
        check_val("rst_byte_ready", DW'(byte_ready), DW'(1));
`ifdef HUFF_PACK_OVF_EN
        check_val("rst_ovf", DW'(overflow), DW'(0));
`endif
        #2 reset = 1'b1;

        // Full block, downstream always ready
        block_ready = 1'b1;
        v = seq_block(8'h01, 20);
        check_val("full_pattern", v[31:0], DW'(32'h04030201));
        expect_block(v, 20);
        send_run(8'h01, 20);
        idle(1'b0);
        @(negedge clk);
        check_val("full_valid_lat", DW'(block_valid), DW'(1));
        check_val("full_count", DW'(block_count), DW'(20));
        @(negedge clk);
        check_val("full_one_cycle", DW'(block_valid), DW'(0));
`ifdef HUFF_PACK_OVF_EN
        check_val("ovf_clear", DW'(overflow), DW'(0));
`endif

        // Back-pressure: three extra bytes must be dropped
        @(posedge clk);
        #1 block_ready = 1'b0;
        expect_block(seq_block(8'h21, 20), 20);
        send_run(8'h21, 20);
        for (int k = 0; k < 3; k++) begin
            send_byte(8'h55, 1'b0);
            @(negedge clk);
            check_val("bp_byte_ready", DW'(byte_ready), DW'(0));
            check_val("bp_data_hold", block_data, seq_block(8'h21, 20));
            check_val("bp_count_hold", DW'(block_count), DW'(20));
        end
        idle(1'b0);
        @(negedge clk);
`ifdef HUFF_PACK_OVF_EN
        check_val("bp_ovf", DW'(overflow), DW'(1));
`endif
        @(posedge clk);
        #1 block_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("bp_release", DW'(block_valid), DW'(0));

        // Back-to-back: handshake edge also accepts 0xA5 as lane 0
        @(posedge clk);
        #1 block_ready = 1'b0;
        expect_block(seq_block(8'h40, 20), 20);
        send_run(8'h40, 20);
        @(posedge clk);
        #1;
        byte_in     = 8'hA5;
        byte_enb    = 1'b1;
        block_ready = 1'b1;
        v = seq_block(8'hB0, 20);
        v[7:0] = 8'hA5;
        expect_block(v, 20);
        send_run(8'hB1, 19);
        idle(1'b0);
        @(negedge clk);
        check_val("b2b_valid", DW'(block_valid), DW'(1));

        // Flush partial block, then flush with nothing collected
        v = '0;
        v[23:0] = 24'hCCBBAA;
        expect_block(v, 3);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        idle(1'b1);
        idle(1'b0);
        @(negedge clk);
        check_val("flush_valid", DW'(block_valid), DW'(1));
        check_val("flush_count", DW'(block_count), DW'(3));
        idle(1'b1);
        idle(1'b0);
        @(negedge clk);
        check_val("flush_empty", DW'(block_valid), DW'(0));
        @(negedge clk);
        check_val("flush_empty2", DW'(block_valid), DW'(0));

        // Asynchronous reset in the middle of a fill
        send_run(8'h70, 7);
        @(posedge clk);
        #1 byte_enb = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_val("arst_data", block_data, DW'(0));
        check_val("arst_valid", DW'(block_valid), DW'(0));
        check_val("arst_count", DW'(block_count), DW'(0));
`ifdef HUFF_PACK_OVF_EN
        check_val("arst_ovf", DW'(overflow), DW'(0));
`endif
        #3 reset = 1'b1;
        expect_block(seq_block(8'h61, 20), 20);
        send_run(8'h61, 20);
        idle(1'b0);
        @(negedge clk);
        check_val("arst_block_valid", DW'(block_valid), DW'(1));

        // Flush coinciding with the 20th byte is a normal full block
        expect_block(seq_block(8'h81, 20), 20);
        send_run(8'h81, 19);
        send_byte(8'h94, 1'b1);
        idle(1'b0);
        @(negedge clk);
        check_val("flast_valid", DW'(block_valid), DW'(1));
        check_val("flast_count", DW'(block_count), DW'(20));
        @(negedge clk);
        check_val("flast_single", DW'(block_valid), DW'(0));

        repeat (3) idle(1'b0);
        @(negedge clk);
        check_val("sb_empty", DW'(sb.size()), DW'(0));
`ifdef HUFF_PACK_OVF_EN
        check_val("end_ovf", DW'(overflow), DW'(0));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
